bsk_prm_writer: RTL and testbench

Bus-master sequencer that sits directly upstream of the BSK PRM command/indication block and drives its asynchronous 16-bit processor bus. On a start request it encodes a 16-bit command word into the PRM's nibble/complement format and writes command registers 00 and 01. It then writes the indication register 10 and the enable key to register 11. Finally it reads back register 00 (command test inputs) and register 11 (password/version/enable status), and reports the results.

---
 rtl/bsk_prm_writer_if.sv | 22 ++
 rtl/bsk_prm_writer.sv | 258 +++++++++++++++++++++++++
 tb/tb_bsk_prm_writer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsk_prm_writer_if.sv
// Asynchronous 16-bit processor bus of the BSK PRM command/indication block.
// The sequencer is the master: it drives address, chip select, strobes and
// write data. The PRM side (or a bus model) returns read data on iD.
interface bsk_prm_writer_if;
  logic [1:0]  oA;
  logic [3:0]  oCS;
  logic        oWr;
  logic        oRd;
  logic [15:0] oD;
  logic        oDOe;
  logic [15:0] iD;

  modport master (
    output oA, oCS, oWr, oRd, oD, oDOe,
    input  iD
  );

  modport slave (
    input  oA, oCS, oWr, oRd, oD, oDOe,
    output iD
  );
endinterface

// File: rtl/bsk_prm_writer.sv
// BSK PRM bus-master sequencer.
// One start request runs six bus accesses in a fixed order:
//   W00 (low command byte), W01 (high command byte), W10 (indication),
//   W11 (enable/disable key), R00 (command test inputs), R11 (status).
// Command bytes are sent in the PRM nibble/complement format.
// All bus outputs are registered so the strobes are glitch-free; they are
// loaded from the decode of the next state, so a registered output always
// matches the state the FSM is in during that cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | bus idle, waiting for iStart
// S_SETUP  | CS/address/data driven, strobe high (T_SETUP cycles)
// S_STROBE | oWr or oRd low (T_PULSE cycles); reads sample iD on the last edge
// S_HOLD   | strobe high, CS/address/data unchanged (T_HOLD cycles)
// S_GAP    | one cycle of idle bus values between accesses
// S_DONE   | one-cycle completion pulse, then back to S_IDLE
module bsk_prm_writer #(
  parameter logic [3:0]  CS       = 4'b0111,
  parameter logic [7:0]  PASSWORD = 8'hA6,
  parameter logic [5:0]  VERSION  = 6'h24,
  parameter logic [7:0]  EN_KEY   = 8'hE1,
  parameter logic [7:0]  DIS_KEY  = 8'h11,
  parameter int unsigned T_SETUP  = 1,
  parameter int unsigned T_PULSE  = 2,
  parameter int unsigned T_HOLD   = 1
) (
  input  logic                    iClk,
  input  logic                    iRes,
  input  logic                    iStart,
  input  logic [15:0]             iCom,
  input  logic [15:0]             iInd,
  input  logic                    iEnable,
  output logic                    oBusy,
  output logic                    oDone,
  output logic [15:0]             oComT,
  output logic [15:0]             oStat,
  output logic                    oVerOk,
  bsk_prm_writer_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  // Phase timers count down to zero; the load value is the length minus one.
  localparam logic [3:0] LP_SETUP_TC = 4'(T_SETUP - 1);
  localparam logic [3:0] LP_PULSE_TC = 4'(T_PULSE - 1);
  localparam logic [3:0] LP_HOLD_TC  = 4'(T_HOLD - 1);
  localparam logic [2:0] LP_LAST_IDX = 3'd5;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [15:0] r_com;
  logic [15:0] r_ind;
  logic        r_en;
  logic [15:0] r_comt;
  logic [15:0] r_stat;
  logic        r_verok;

  logic [1:0]  r_a;
  logic [3:0]  r_cs;
  logic        r_wr;
  logic        r_rd;
  logic [15:0] r_d;
  logic        r_doe;
  logic        r_busy;
  logic        r_done;

  state_t      w_state_nxt;
  logic [2:0]  w_idx_nxt;
  logic [3:0]  w_cnt_nxt;
  logic        w_latch;
  logic        w_sample;
  logic        w_rd_cur;

  logic [15:0] w_com_nxt;
  logic [15:0] w_ind_nxt;
  logic        w_en_nxt;

  logic        w_act_nxt;
  logic        w_wr_acc_nxt;
  logic [1:0]  w_addr_nxt;
  logic [15:0] w_wdata_nxt;

  // PRM command register format: each nibble followed by its complement.
  function automatic logic [15:0] f_enc(input logic [7:0] c);
    return {c[7:4], ~c[7:4], c[3:0], ~c[3:0]};
  endfunction

  assign w_rd_cur  = (r_idx >= 3'd4);
  assign w_com_nxt = w_latch ? iCom    : r_com;
  assign w_ind_nxt = w_latch ? iInd    : r_ind;
  assign w_en_nxt  = w_latch ? iEnable : r_en;

  // Next-state, access index and phase timer.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_sample    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_state_nxt = S_SETUP;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = LP_SETUP_TC;
          w_latch     = 1'b1;
        end
      end
      S_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = LP_PULSE_TC;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_STROBE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = LP_HOLD_TC;
          w_sample    = w_rd_cur;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_GAP: begin
        if (r_idx == LP_LAST_IDX) begin
          w_state_nxt = S_DONE;
          w_idx_nxt   = 3'd0;
        end else begin
          w_state_nxt = S_SETUP;
          w_idx_nxt   = r_idx + 3'd1;
          w_cnt_nxt   = LP_SETUP_TC;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  // Address and write data of the access selected by the next index.
  always_comb begin
    w_addr_nxt  = 2'b00;
    w_wdata_nxt = 16'h0000;
    unique case (w_idx_nxt)
      3'd0: begin w_addr_nxt = 2'b00; w_wdata_nxt = f_enc(w_com_nxt[7:0]);  end
      3'd1: begin w_addr_nxt = 2'b01; w_wdata_nxt = f_enc(w_com_nxt[15:8]); end
      3'd2: begin w_addr_nxt = 2'b10; w_wdata_nxt = w_ind_nxt;              end
      3'd3: begin w_addr_nxt = 2'b11; w_wdata_nxt = {8'h00, w_en_nxt ? EN_KEY : DIS_KEY}; end
      3'd4: begin w_addr_nxt = 2'b00; end
      3'd5: begin w_addr_nxt = 2'b11; end
      default: begin w_addr_nxt = 2'b00; end
    endcase
  end

  assign w_act_nxt    = (w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE) ||
                        (w_state_nxt == S_HOLD);
  assign w_wr_acc_nxt = (w_idx_nxt < 3'd4);

  // FSM state, access index and phase timer.
  always_ff @(posedge iClk) begin
    if (!iRes) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request inputs once, on the accepted start.
  always_ff @(posedge iClk) begin
    if (!iRes) begin
      r_com <= 16'h0000;
      r_ind <= 16'h0000;
      r_en  <= 1'b0;
    end else if (w_latch) begin
      r_com <= iCom;
      r_ind <= iInd;
      r_en  <= iEnable;
    end
  end

  // Readback results; each register keeps its value until its next read.
  always_ff @(posedge iClk) begin
    if (!iRes) begin
      r_comt  <= 16'h0000;
      r_stat  <= 16'h0000;
      r_verok <= 1'b0;
    end else if (w_sample) begin
      if (r_idx == 3'd4) begin
        r_comt <= bus.iD;
      end else begin
        r_stat  <= bus.iD;
        r_verok <= (bus.iD == {PASSWORD, VERSION, 1'b1, r_en});
      end
    end
  end

  // Registered bus and status outputs, decoded from the next state.
  always_ff @(posedge iClk) begin
    if (!iRes) begin
      r_a    <= 2'b00;
      r_cs   <= ~CS;
      r_wr   <= 1'b1;
      r_rd   <= 1'b1;
      r_d    <= 16'h0000;
      r_doe  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_a    <= w_act_nxt ? w_addr_nxt : 2'b00;
      r_cs   <= w_act_nxt ? CS : ~CS;
      r_wr   <= !((w_state_nxt == S_STROBE) && w_wr_acc_nxt);
      r_rd   <= !((w_state_nxt == S_STROBE) && !w_wr_acc_nxt);
      r_d    <= (w_act_nxt && w_wr_acc_nxt) ? w_wdata_nxt : 16'h0000;
      r_doe  <= w_act_nxt && w_wr_acc_nxt;
      r_busy <= w_act_nxt || (w_state_nxt == S_GAP);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.oA   = r_a;
  assign bus.oCS  = r_cs;
  assign bus.oWr  = r_wr;
  assign bus.oRd  = r_rd;
  assign bus.oD   = r_d;
  assign bus.oDOe = r_doe;
  assign oBusy    = r_busy;
  assign oDone    = r_done;
  assign oComT    = r_comt;
  assign oStat    = r_stat;
  assign oVerOk   = r_verok;

endmodule

// File: tb/tb_bsk_prm_writer.sv
// Bench for bsk_prm_writer: two instances (default timing and 3/4/2 timing)
// share the request inputs; each has its own bus with a PRM read model.
module tb_bsk_prm_writer;

  localparam logic [3:0] CS = 4'b0111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] com, ind;
  logic        en;
  logic        busy [2];
  logic        done [2];
  logic        verok [2];
  logic [15:0] comt [2];
  logic [15:0] stat [2];
  logic [15:0] m_comt, m_stat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsk_prm_writer_if bus0 ();
  bsk_prm_writer_if bus1 ();

  assign bus0.iD = (!bus0.oRd) ? ((bus0.oA == 2'b00) ? m_comt : m_stat) : 16'h5A5A;
  assign bus1.iD = (!bus1.oRd) ? ((bus1.oA == 2'b00) ? m_comt : m_stat) : 16'h5A5A;

  bsk_prm_writer u_dut0 (
    .iClk(clk), .iRes(rst_n), .iStart(start), .iCom(com), .iInd(ind),
    .iEnable(en), .oBusy(busy[0]), .oDone(done[0]), .oComT(comt[0]),
    .oStat(stat[0]), .oVerOk(verok[0]), .bus(bus0)
  );

  bsk_prm_writer #(.T_SETUP(3), .T_PULSE(4), .T_HOLD(2)) u_dut1 (
    .iClk(clk), .iRes(rst_n), .iStart(start), .iCom(com), .iInd(ind),
    .iEnable(en), .oBusy(busy[1]), .oDone(done[1]), .oComT(comt[1]),
    .oStat(stat[1]), .oVerOk(verok[1]), .bus(bus1)
  );

  // ---------------- bus monitor: records each access and protocol breaches
  typedef struct {
    logic [1:0]  a;
    logic [15:0] d;
    logic        wr;
    int          su;
    int          pw;
    int          ho;
  } acc_t;

  acc_t        log0[$];
  acc_t        log1[$];
  int          viol [2];
  logic        p_act [2], p_strb [2], seen [2], cur_wr [2];
  logic [1:0]  p_a [2];
  logic [15:0] p_d [2];
  int          su_c [2], pw_c [2], ho_c [2];

  task automatic mon(input int u, input logic [3:0] cs, input logic [1:0] a,
                     input logic wr, input logic rd, input logic [15:0] d,
                     input logic doe);
    logic act, strb;
    acc_t r;
    act  = (cs == CS);
    strb = !wr || !rd;
    if (cs != CS && cs != ~CS) viol[u]++;
    if (!wr && !rd) viol[u]++;
    if (strb && !act) viol[u]++;
    if (doe && (!act || !rd)) viol[u]++;
    if (act && p_act[u] && (a != p_a[u] || d != p_d[u])) viol[u]++;
    if (act) begin
      if (strb) begin
        if (!p_strb[u] && seen[u]) viol[u]++;
        pw_c[u]++;
        seen[u]   = 1'b1;
        cur_wr[u] = !wr;
      end else if (seen[u]) ho_c[u]++;
      else su_c[u]++;
    end else if (p_act[u]) begin
      r.a = p_a[u]; r.d = p_d[u]; r.wr = cur_wr[u];
      r.su = su_c[u]; r.pw = pw_c[u]; r.ho = ho_c[u];
      if (u == 0) log0.push_back(r); else log1.push_back(r);
      su_c[u] = 0; pw_c[u] = 0; ho_c[u] = 0; seen[u] = 1'b0;
    end
    p_act[u] = act; p_strb[u] = strb; p_a[u] = a; p_d[u] = d;
  endtask

  always @(negedge clk) begin
    mon(0, bus0.oCS, bus0.oA, bus0.oWr, bus0.oRd, bus0.oD, bus0.oDOe);
    mon(1, bus1.oCS, bus1.oA, bus1.oWr, bus1.oRd, bus1.oD, bus1.oDOe);
  end

  function automatic int lsz(input int u);
    return (u == 0) ? log0.size() : log1.size();
  endfunction

  function automatic acc_t lg(input int u, input int i);
    return (u == 0) ? log0[i] : log1[i];
  endfunction

  function automatic logic [42:0] pk(input acc_t r);
    return {r.a, r.wr, r.wr ? r.d : 16'h0000, 8'(r.su), 8'(r.pw), 8'(r.ho)};
  endfunction

  // ---------------- reference model: the six accesses of one transaction
  function automatic logic [15:0] enc8(input logic [7:0] c);
    return {c[7:4], ~c[7:4], c[3:0], ~c[3:0]};
  endfunction

  function automatic logic [42:0] exp_pk(input int u, input int i, input logic [15:0] c,
                                         input logic [15:0] id, input logic e);
    logic [1:0]  a;
    logic [15:0] d;
    int su, pw, ho;
    d = 16'h0000;
    case (i)
      0: begin a = 2'b00; d = enc8(c[7:0]);  end
      1: begin a = 2'b01; d = enc8(c[15:8]); end
      2: begin a = 2'b10; d = id;            end
      3: begin a = 2'b11; d = {8'h00, e ? 8'hE1 : 8'h11}; end
      4: a = 2'b00;
      default: a = 2'b11;
    endcase
    su = (u == 0) ? 1 : 3;
    pw = (u == 0) ? 2 : 4;
    ho = (u == 0) ? 1 : 2;
    return {a, (i < 4) ? 1'b1 : 1'b0, d, 8'(su), 8'(pw), 8'(ho)};
  endfunction

  function automatic logic exp_ok(input logic [15:0] ms, input logic e);
    return ms == {8'hA6, 6'h24, 1'b1, e};
  endfunction

  function automatic int exp_done(input int u);
    return (u == 0) ? 6 * (1 + 2 + 1 + 1) + 1 : 6 * (3 + 4 + 2 + 1) + 1;
  endfunction

  function automatic logic [24:0] bus_snap(input int u);
    if (u == 0) return {bus0.oCS, bus0.oA, bus0.oWr, bus0.oRd, bus0.oD, bus0.oDOe};
    return {bus1.oCS, bus1.oA, bus1.oWr, bus1.oRd, bus1.oD, bus1.oDOe};
  endfunction

  localparam logic [24:0] IDLE_BUS = {4'b1000, 2'b00, 1'b1, 1'b1, 16'h0000, 1'b0};

  // ---------------- stimulus driver (observations only, no comparisons)
  int done_at [2], done_cnt [2], busy_bad [2];

  task automatic run_txn(input logic [15:0] c, input logic [15:0] id, input logic e,
                         input logic [15:0] mc, input logic [15:0] ms, input bit disturb);
    com = c; ind = id; en = e; m_comt = mc; m_stat = ms;
    log0.delete(); log1.delete();
    done_at = '{0, 0}; done_cnt = '{0, 0}; busy_bad = '{0, 0};
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (disturb) begin
        if (n == 3) begin com = 16'($urandom); ind = 16'($urandom); en = ~en; end
        if (n == 5 || n == 15 || n == 25) start = 1'b1;
        if (n == 6 || n == 16 || n == 26) start = 1'b0;
      end
      for (int u = 0; u < 2; u++) begin
        if (done[u]) begin
          done_cnt[u]++;
          if (done_at[u] == 0) done_at[u] = n;
          if (busy[u]) busy_bad[u]++;
        end else if (done_at[u] == 0 && !busy[u]) busy_bad[u]++;
      end
    end
  endtask

  // ---------------- tests
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; com = 16'h0; ind = 16'h0; en = 1'b0;
    m_comt = 16'h0; m_stat = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (bus_snap(u) !== IDLE_BUS) begin
        errors++; $display("FAIL reset_bus u%0d got %h want %h", u, bus_snap(u), IDLE_BUS);
      end
      checks++;
      if ({busy[u], done[u], verok[u], comt[u], stat[u]} !== 35'h0) begin
        errors++; $display("FAIL reset_status u%0d busy %b done %b verok %b comt %h stat %h",
                           u, busy[u], done[u], verok[u], comt[u], stat[u]);
      end
    end
  endtask

  task automatic test_basic_and_timing();
    run_txn(16'hF7A5, 16'h1234, 1'b1, 16'h987F, 16'hA693, 1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (lsz(u) !== 6) begin errors++; $display("FAIL basic_count u%0d got %0d want 6", u, lsz(u)); end
      for (int i = 0; i < 6 && i < lsz(u); i++) begin
        checks++;
        if (pk(lg(u, i)) !== exp_pk(u, i, 16'hF7A5, 16'h1234, 1'b1)) begin
          errors++; $display("FAIL basic_access u%0d #%0d got %h want %h", u, i,
                             pk(lg(u, i)), exp_pk(u, i, 16'hF7A5, 16'h1234, 1'b1));
        end
      end
      checks++;
      if (done_at[u] !== exp_done(u) || done_cnt[u] !== 1) begin
        errors++; $display("FAIL basic_done u%0d got cycle %0d x%0d want cycle %0d x1",
                           u, done_at[u], done_cnt[u], exp_done(u));
      end
      checks++;
      if (busy_bad[u] !== 0) begin errors++; $display("FAIL basic_busy u%0d got %0d bad cycles want 0", u, busy_bad[u]); end
      checks++;
      if ({comt[u], stat[u], verok[u]} !== {16'h987F, 16'hA693, 1'b1}) begin
        errors++; $display("FAIL basic_result u%0d got %h %h %b want 987f a693 1", u, comt[u], stat[u], verok[u]);
      end
      checks++;
      if (viol[u] !== 0) begin errors++; $display("FAIL protocol u%0d got %0d violations want 0", u, viol[u]); end
    end
    m_comt = 16'h0000; m_stat = 16'h0000;
    repeat (5) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({comt[u], stat[u]} !== {16'h987F, 16'hA693}) begin
        errors++; $display("FAIL result_hold u%0d got %h %h want 987f a693", u, comt[u], stat[u]);
      end
    end
  endtask

  task automatic test_disable();
    logic [15:0] ms [2];
    ms[0] = 16'hA692; ms[1] = 16'hA693;
    for (int k = 0; k < 2; k++) begin
      run_txn(16'hF7A5, 16'h1234, 1'b0, 16'h987F, ms[k], 1'b0);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (lsz(u) < 4 || pk(lg(u, 3)) !== exp_pk(u, 3, 16'hF7A5, 16'h1234, 1'b0)) begin
          errors++; $display("FAIL disable_key u%0d got %h want %h", u,
                             (lsz(u) < 4) ? 43'h0 : pk(lg(u, 3)), exp_pk(u, 3, 16'hF7A5, 16'h1234, 1'b0));
        end
        checks++;
        if ({stat[u], verok[u]} !== {ms[k], (k == 0) ? 1'b1 : 1'b0}) begin
          errors++; $display("FAIL disable_verok u%0d got %h %b want %h %b", u, stat[u], verok[u],
                             ms[k], (k == 0) ? 1'b1 : 1'b0);
        end
      end
    end
  endtask

  task automatic test_ignore_and_latch();
    logic [15:0] c, id, ms;
    c = 16'($urandom); id = 16'($urandom); ms = {8'hA6, 6'h24, 1'b1, 1'b1};
    run_txn(c, id, 1'b1, 16'($urandom), ms, 1'b1);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (lsz(u) !== 6) begin errors++; $display("FAIL ignore_count u%0d got %0d want 6", u, lsz(u)); end
      for (int i = 0; i < 4 && i < lsz(u); i++) begin
        checks++;
        if (pk(lg(u, i)) !== exp_pk(u, i, c, id, 1'b1)) begin
          errors++; $display("FAIL latch_data u%0d #%0d got %h want %h", u, i, pk(lg(u, i)), exp_pk(u, i, c, id, 1'b1));
        end
      end
      checks++;
      if (done_at[u] !== exp_done(u) || done_cnt[u] !== 1 || verok[u] !== 1'b1) begin
        errors++; $display("FAIL ignore_done u%0d got cycle %0d x%0d verok %b want cycle %0d x1 verok 1",
                           u, done_at[u], done_cnt[u], verok[u], exp_done(u));
      end
    end
  endtask

  task automatic test_back_to_back();
    int d0[$], d1[$];
    com = 16'h1357; ind = 16'h2468; en = 1'b1;
    log0.delete(); log1.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 130; n++) begin
      @(negedge clk);
      if (done[0]) begin d0.push_back(n); if (d0.size() == 2) start = 1'b0; end
      if (done[1]) d1.push_back(n);
    end
    start = 1'b0;
    checks++;
    if (d0.size() !== 2 || d1.size() !== 2) begin
      errors++; $display("FAIL b2b_count got %0d/%0d done pulses want 2/2", d0.size(), d1.size());
    end else begin
      checks++;
      if (d0[0] !== 31 || d0[1] !== 63 || d1[0] !== 61 || d1[1] !== 123) begin
        errors++; $display("FAIL b2b_timing got %0d,%0d / %0d,%0d want 31,63 / 61,123", d0[0], d0[1], d1[0], d1[1]);
      end
    end
    checks++;
    if (lsz(0) !== 12 || lsz(1) !== 12) begin
      errors++; $display("FAIL b2b_accesses got %0d/%0d want 12/12", lsz(0), lsz(1));
    end
  endtask

  task automatic test_reset_mid();
    int found, dn;
    com = 16'hC3C3; ind = 16'h0F0F; en = 1'b1; m_comt = 16'h1111; m_stat = 16'h2222;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    found = 0;
    for (int n = 1; n <= 40 && found == 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus0.oWr == 1'b0 && bus0.oA == 2'b10) found = n;
    end
    checks++;
    if (found == 0) begin errors++; $display("FAIL rst_mid_wait got no idx2 strobe want one within 40 cycles"); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (bus_snap(u) !== IDLE_BUS) begin
        errors++; $display("FAIL rst_mid_bus u%0d got %h want %h", u, bus_snap(u), IDLE_BUS);
      end
      checks++;
      if ({busy[u], done[u], verok[u], comt[u], stat[u]} !== 35'h0) begin
        errors++; $display("FAIL rst_mid_status u%0d busy %b done %b verok %b comt %h stat %h",
                           u, busy[u], done[u], verok[u], comt[u], stat[u]);
      end
    end
    dn = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (done[0] || done[1] || busy[0] || busy[1]) dn++;
    end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", dn); end
    run_txn(16'hF7A5, 16'h1234, 1'b1, 16'h987F, 16'hA693, 1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (done_at[u] !== exp_done(u) || {comt[u], stat[u], verok[u]} !== {16'h987F, 16'hA693, 1'b1}) begin
        errors++; $display("FAIL rst_recover u%0d got cycle %0d %h %h %b want cycle %0d 987f a693 1",
                           u, done_at[u], comt[u], stat[u], verok[u], exp_done(u));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] c, id, mc, ms;
    logic e;
    for (int t = 0; t < 6; t++) begin
      c = 16'($urandom); id = 16'($urandom); mc = 16'($urandom); e = 1'($urandom);
      ms = ($urandom_range(0, 1) == 1) ? {8'hA6, 6'h24, 1'b1, e} : 16'($urandom);
      run_txn(c, id, e, mc, ms, 1'b0);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (lsz(u) !== 6) begin errors++; $display("FAIL rand_count t%0d u%0d got %0d want 6", t, u, lsz(u)); end
        for (int i = 0; i < 6 && i < lsz(u); i++) begin
          checks++;
          if (pk(lg(u, i)) !== exp_pk(u, i, c, id, e)) begin
            errors++; $display("FAIL rand_access t%0d u%0d #%0d got %h want %h", t, u, i, pk(lg(u, i)), exp_pk(u, i, c, id, e));
          end
        end
        checks++;
        if ({comt[u], stat[u], verok[u]} !== {mc, ms, exp_ok(ms, e)} || done_at[u] !== exp_done(u)) begin
          errors++; $display("FAIL rand_result t%0d u%0d got %h %h %b cycle %0d want %h %h %b cycle %0d",
                             t, u, comt[u], stat[u], verok[u], done_at[u], mc, ms, exp_ok(ms, e), exp_done(u));
        end
      end
    end
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (viol[u] !== 0) begin errors++; $display("FAIL protocol_final u%0d got %0d violations want 0", u, viol[u]); end
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      viol[u] = 0; p_act[u] = 1'b0; p_strb[u] = 1'b0; seen[u] = 1'b0; cur_wr[u] = 1'b0;
      p_a[u] = 2'b00; p_d[u] = 16'h0; su_c[u] = 0; pw_c[u] = 0; ho_c[u] = 0;
    end
    test_reset();
    test_basic_and_timing();
    test_disable();
    test_ignore_and_latch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
